hazard_fwd_ctrl: RTL

Parametrised hazard and forwarding controller for the pipelined core. It generalises operand forwarding to any number of source operands and forwarding stages. It adds a registered scoreboard for a fixed-latency multiply/divide unit, and generates load-use and multi-cycle stalls. It sits beside the ID/EX register: it drives the EX operand muxes, and drives the stall/bubble controls of the PC, IF/ID and ID/EX registers.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_fwd_ctrl_md_scoreboard.sv | 62 ++++++
 rtl/hazard_fwd_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: register width default,
// forward-select encoding and mul/div latency bounds.
package hazard_pkg;

  localparam int RW_DEF     = 5;
  localparam int FWD_RF     = 0;
  localparam int MD_LAT_MIN = 2;
  localparam int MD_LAT_MAX = 15;
  localparam int MD_CNT_W   = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Stage i (0 = nearest) forwards with code NUM_STG-i; 0 selects the register file.
  function automatic int fwd_enc(input int num_stg, input int stg);
    return num_stg - stg;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_scoreboard.sv
// Fixed-latency mul/div scoreboard: IDLE/BUSY FSM, countdown, pending destination
// and the mul/div stall term for the instruction in ID.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int RW      = RW_DEF,
  parameter int MD_LAT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               md_issue,
  input  logic [RW-1:0]      md_rd,
  input  logic [NUM_SRC*RW-1:0] if_id_src,
  input  logic [NUM_SRC-1:0] if_id_src_vld,
  input  logic               if_id_is_md,
  output md_state_e          md_state,
  output logic               md_done,
  output logic               md_stall
);

  // Out-of-range latencies are clamped so the 4-bit counter stays meaningful.
  localparam int LAT = (MD_LAT < MD_LAT_MIN) ? MD_LAT_MIN :
                       (MD_LAT > MD_LAT_MAX) ? MD_LAT_MAX : MD_LAT;

  logic [MD_CNT_W-1:0] md_cnt;
  logic [RW-1:0]       md_rd_q;
  logic                busy_live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      md_rd_q  <= '0;
    end else if (md_issue) begin
      md_state <= MD_BUSY;
      md_cnt   <= MD_CNT_W'(LAT - 1);
      md_rd_q  <= md_rd;
    end else if (md_state == MD_BUSY) begin
      if (md_cnt == '0) md_state <= MD_IDLE;
      else              md_cnt   <= md_cnt - MD_CNT_W'(1);
    end
  end

  assign md_done   = (md_state == MD_BUSY) && (md_cnt == '0);
  assign busy_live = (md_state == MD_BUSY) && !md_done;

  // The issue-cycle term covers the result that is not yet in md_rd_q.
  always_comb begin
    md_stall = busy_live && if_id_is_md;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (if_id_src_vld[s]) begin
        if (busy_live && md_rd_q != '0 && if_id_src[s*RW +: RW] == md_rd_q)
          md_stall = 1'b1;
        if (md_issue && md_rd != '0 && if_id_src[s*RW +: RW] == md_rd)
          md_stall = 1'b1;
      end
    end
    md_stall = md_stall && rst_n;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding, load-use and mul/div stall control beside the ID/EX register.
// Optional stall performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2,
  parameter int RW      = RW_DEF,
  parameter int MD_LAT  = 4,
  parameter int SELW    = $clog2(NUM_STG + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_STG-1:0]      stg_regwrite,
  input  logic [NUM_STG*RW-1:0]   stg_rd,
  input  logic [NUM_SRC*RW-1:0]   id_ex_src,
  input  logic [NUM_SRC-1:0]      id_ex_src_vld,
  input  logic                    id_ex_memread,
  input  logic [RW-1:0]           id_ex_rd,
  input  logic [NUM_SRC*RW-1:0]   if_id_src,
  input  logic [NUM_SRC-1:0]      if_id_src_vld,
  input  logic                    if_id_is_md,
  input  logic                    md_issue,
  input  logic [RW-1:0]           md_rd,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    stall_id,
  output logic                    md_done,
  output logic                    md_busy,
  output logic [31:0]             perf_lu_stalls,
  output logic [31:0]             perf_md_stalls
);

  logic      lu_stall;
  logic      md_stall;
  md_state_e md_state;

  // Scanning from the oldest stage down lets the nearest match overwrite.
  always_comb begin
    fwd_sel = {NUM_SRC{SELW'(FWD_RF)}};
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = NUM_STG - 1; i >= 0; i--) begin
        if (id_ex_src_vld[s] && stg_regwrite[i] && stg_rd[i*RW +: RW] != '0 &&
            stg_rd[i*RW +: RW] == id_ex_src[s*RW +: RW])
          fwd_sel[s*SELW +: SELW] = SELW'(fwd_enc(NUM_STG, i));
      end
    end
  end

  always_comb begin
    lu_stall = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_ex_memread && id_ex_rd != '0 && if_id_src_vld[s] &&
          if_id_src[s*RW +: RW] == id_ex_rd)
        lu_stall = 1'b1;
    end
  end

  md_scoreboard #(
    .NUM_SRC(NUM_SRC),
    .RW     (RW),
    .MD_LAT (MD_LAT)
  ) u_md_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .md_issue     (md_issue),
    .md_rd        (md_rd),
    .if_id_src    (if_id_src),
    .if_id_src_vld(if_id_src_vld),
    .if_id_is_md  (if_id_is_md),
    .md_state     (md_state),
    .md_done      (md_done),
    .md_stall     (md_stall)
  );

  assign md_busy  = (md_state == MD_BUSY);
  assign stall_id = lu_stall | md_stall;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_q;
  logic [31:0] perf_md_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q <= '0;
      perf_md_q <= '0;
    end else begin
      if (lu_stall && perf_lu_q != '1) perf_lu_q <= perf_lu_q + 32'd1;
      if (md_stall && perf_md_q != '1) perf_md_q <= perf_md_q + 32'd1;
    end
  end

  assign perf_lu_stalls = perf_lu_q;
  assign perf_md_stalls = perf_md_q;
`else
  assign perf_lu_stalls = '0;
  assign perf_md_stalls = '0;
`endif

endmodule
